fe_capture_sequencer: RTL and testbench
=======================================

// Module: fe_capture_sequencer
// PURPOSE
//  Sequences the front-end capture datapath: after arm, waits for trigger edges, applies a
//  programmable delay, then drives the datapath's capture-enable for a programmed window.
//  Repeats for N triggers, then reports done. Sits in the fe_clk domain; drives I_capture_enable
//  of the capture datapath and receives its capture_allowed status.
// PARAMETERS
//  pDELAY_WIDTH  20  width of trigger-to-capture delay, in fe_clk cycles
//  pWIDTH_WIDTH  20  width of capture window length, in fe_clk cycles
//  pCOUNT_WIDTH   8  width of trigger count
// PORTS
//  fe_clk            in   1   front-end clock; the only clock
//  reset_n           in   1   synchronous, active-low reset
//  I_arm             in   1   arm level, already synchronised to fe_clk
//  I_abort           in   1   single-cycle abort request
//  I_trigger         in   1   trigger level from target/pattern match, synchronous to fe_clk
//  I_trigger_delay   in   pDELAY_WIDTH  delay D
//  I_capture_width   in   pWIDTH_WIDTH  window W; 0 = until datapath stops capturing
//  I_num_triggers    in   pCOUNT_WIDTH  trigger count N; 0 treated as 1
//  I_capturing       in   1   capture_allowed from the datapath
//  O_capture_enable  out  1   drives datapath capture enable
//  O_armed           out  1   high in ARMED, DELAY, CAPTURE, HOLDOFF
//  O_done            out  1   high in DONE
//  O_trig_count      out  pCOUNT_WIDTH  completed capture windows since last arm
//  O_state           out  3   FSM state, for debug
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): state IDLE; all outputs 0; all counters and edge registers 0.
//  - arm_rise = I_arm & ~arm_r. trig_rise = I_trigger & ~trig_r. arm_r and trig_r are 1-cycle registers.
//  - D, W and N are latched on arm_rise. Register changes mid-sequence have no effect.
//  - State encodings: IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, HOLDOFF=4, DONE=5.
//  - Priority in every state: reset > I_abort > (!I_arm) > normal transition.
//  - I_abort or I_arm low in any state except IDLE: next state is IDLE.
//    * O_capture_enable falls on that edge.
//    * O_trig_count holds its value until the next arm_rise.
//  - IDLE or DONE, arm_rise: go to ARMED and clear O_trig_count.
//  - ARMED: trig_rise goes to DELAY and loads delay_cnt=D; if D==0, go directly to CAPTURE.
//    * trig_rise on the same cycle as arm_rise is ignored, because the state is not yet ARMED.
//  - DELAY: delay_cnt decrements by 1 per cycle; at delay_cnt==1, go to CAPTURE.
//  - O_capture_enable is registered and equals (state==CAPTURE).
//    * Latency: it is first high D+1 cycles after the edge sampling trig_rise.
//  - CAPTURE, W>0: O_capture_enable is high for exactly W cycles.
//  - CAPTURE, W==0:
//    * seen_cap sets when I_capturing=1.
//    * Capture ends on the first cycle with seen_cap=1 and I_capturing=0.
//    * O_capture_enable falls on the next edge.
//  - End of CAPTURE: O_trig_count increments.
//    * If the new count >= max(N,1), go to DONE; otherwise go to HOLDOFF.
//  - HOLDOFF: wait until I_trigger==0, then go to ARMED.
//    * A trigger held high across a window never counts twice.
//  - trig_rise in DELAY, CAPTURE or HOLDOFF is ignored (no queueing).
//  - DONE: hold until I_arm falls (go to IDLE) or an abort occurs. O_done stays high while in DONE.
//  - Counter widths:
//    * delay_cnt is pDELAY_WIDTH bits; win_cnt is pWIDTH_WIDTH bits.
//    * D=2^pDELAY_WIDTH-1 is legal with no wrap.
//    * O_trig_count saturates at all-ones and never wraps.
// TESTING
//  1. Reset, then D=0, W=4, N=1, arm. trig_rise sampled at edge t.
//     -> enable high at edges t+1..t+4; DONE at t+5; O_trig_count=1; O_done=1.
//  2. D=10, W=3, N=3. Three trigger pulses spaced 30 cycles apart.
//     -> each window starts 11 cycles after its trig_rise and lasts 3 cycles; DONE after the third; count=3.
//  3. N=2, I_trigger held high across the first window.
//     -> stays in HOLDOFF until I_trigger=0; the second window comes only after a new rise.
//  4. W=0, I_capturing rises then falls 50 cycles later.
//     -> enable falls 1 cycle after I_capturing=0; count=1.
//  5. I_abort mid-CAPTURE; separately, reset_n=0 mid-DELAY.
//     -> abort: enable low next edge, state IDLE, count held. Reset: all outputs 0 next edge.
//  6. N=0, with arm_rise and trig_rise on the same cycle.
//     -> that trigger is ignored; the next trig_rise captures once; then DONE.

Source files
------------

// File: rtl/fe_capture_sequencer.sv
// Front-end capture sequencer: arm, trigger, delay, then a capture window,
// repeated for N triggers before reporting done.
module fe_capture_sequencer #(
  parameter int pDELAY_WIDTH = 20,
  parameter int pWIDTH_WIDTH = 20,
  parameter int pCOUNT_WIDTH = 8
) (
  input  logic                    fe_clk,
  input  logic                    reset_n,
  input  logic                    I_arm,
  input  logic                    I_abort,
  input  logic                    I_trigger,
  input  logic [pDELAY_WIDTH-1:0] I_trigger_delay,
  input  logic [pWIDTH_WIDTH-1:0] I_capture_width,
  input  logic [pCOUNT_WIDTH-1:0] I_num_triggers,
  input  logic                    I_capturing,
  output logic                    O_capture_enable,
  output logic                    O_armed,
  output logic                    O_done,
  output logic [pCOUNT_WIDTH-1:0] O_trig_count,
  output logic [2:0]              O_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARMED   = 3'd1;
  localparam logic [2:0] DELAY   = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] HOLDOFF = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [pDELAY_WIDTH-1:0] D_ONE = 1;
  localparam logic [pWIDTH_WIDTH-1:0] W_ONE = 1;
  localparam logic [pWIDTH_WIDTH-1:0] W_ZERO = '0;
  localparam logic [pCOUNT_WIDTH-1:0] N_ONE = 1;

  logic [2:0]              state;
  logic [2:0]              state_nx;
  logic                    arm_r;
  logic                    trig_r;
  logic [pDELAY_WIDTH-1:0] d_lat;
  logic [pWIDTH_WIDTH-1:0] w_lat;
  logic [pCOUNT_WIDTH-1:0] n_lat;
  logic [pDELAY_WIDTH-1:0] delay_cnt;
  logic [pWIDTH_WIDTH-1:0] win_cnt;
  logic                    seen_cap;
  logic [pCOUNT_WIDTH-1:0] trig_count;
  logic                    cap_en;

  logic                    arm_rise;
  logic                    trig_rise;
  logic                    win_end;
  logic [pCOUNT_WIDTH-1:0] cnt_inc;
  logic [pCOUNT_WIDTH-1:0] n_eff;

  assign arm_rise  = I_arm & ~arm_r;
  assign trig_rise = I_trigger & ~trig_r;

  // W==0 means the window follows the datapath's own capture activity
  assign win_end = (w_lat != W_ZERO) ? (win_cnt == W_ONE)
                                     : (seen_cap & ~I_capturing);

  assign cnt_inc = (&trig_count) ? trig_count : trig_count + N_ONE;
  assign n_eff   = (n_lat == '0) ? N_ONE : n_lat;

  always_comb begin
    state_nx = state;
    if (I_abort) begin
      state_nx = IDLE;
    end else if (!I_arm) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arm_rise) state_nx = ARMED;
        end
        ARMED: begin
          if (trig_rise)
            state_nx = (d_lat == '0) ? CAPTURE : DELAY;
        end
        DELAY: begin
          if (delay_cnt == D_ONE) state_nx = CAPTURE;
        end
        CAPTURE: begin
          if (win_end)
            state_nx = (cnt_inc >= n_eff) ? DONE : HOLDOFF;
        end
        HOLDOFF: begin
          if (!I_trigger) state_nx = ARMED;
        end
        DONE: begin
          if (arm_rise) state_nx = ARMED;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge fe_clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      arm_r      <= 1'b0;
      trig_r     <= 1'b0;
      d_lat      <= '0;
      w_lat      <= '0;
      n_lat      <= '0;
      delay_cnt  <= '0;
      win_cnt    <= '0;
      seen_cap   <= 1'b0;
      trig_count <= '0;
      cap_en     <= 1'b0;
    end else begin
      state  <= state_nx;
      arm_r  <= I_arm;
      trig_r <= I_trigger;
      cap_en <= (state_nx == CAPTURE);

      if (arm_rise) begin
        d_lat <= I_trigger_delay;
        w_lat <= I_capture_width;
        n_lat <= I_num_triggers;
      end

      if ((state == IDLE || state == DONE) && state_nx == ARMED)
        trig_count <= '0;
      else if (state == CAPTURE &&
               (state_nx == DONE || state_nx == HOLDOFF))
        trig_count <= cnt_inc;

      if (state == ARMED && state_nx == DELAY)
        delay_cnt <= d_lat;
      else if (state == DELAY)
        delay_cnt <= delay_cnt - D_ONE;

      if (state != CAPTURE && state_nx == CAPTURE) begin
        win_cnt  <= w_lat;
        seen_cap <= 1'b0;
      end else if (state == CAPTURE) begin
        if (win_cnt != W_ZERO) win_cnt <= win_cnt - W_ONE;
        if (I_capturing) seen_cap <= 1'b1;
      end
    end
  end

  assign O_capture_enable = cap_en;
  assign O_armed = (state == ARMED) || (state == DELAY) ||
                   (state == CAPTURE) || (state == HOLDOFF);
  assign O_done       = (state == DONE);
  assign O_trig_count = trig_count;
  assign O_state      = state;

endmodule

// File: tb/tb_fe_capture_sequencer.sv
// Bench for fe_capture_sequencer: directed scenarios plus randomized
// traffic, all checked against a timestamp-based reference model.
module tb_fe_capture_sequencer;

  localparam int DW = 20;
  localparam int WW = 20;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm, abort, trig, capturing;
  logic [DW-1:0] dly;
  logic [WW-1:0] wid;
  logic [CW-1:0] num;
  logic          en, armed, done;
  logic [CW-1:0] cnt;
  logic [2:0]    st;

  int checks = 0;
  int errors = 0;

  fe_capture_sequencer #(
    .pDELAY_WIDTH(DW),
    .pWIDTH_WIDTH(WW),
    .pCOUNT_WIDTH(CW)
  ) dut (
    .fe_clk(clk),
    .reset_n(rst_n),
    .I_arm(arm),
    .I_abort(abort),
    .I_trigger(trig),
    .I_trigger_delay(dly),
    .I_capture_width(wid),
    .I_num_triggers(num),
    .I_capturing(capturing),
    .O_capture_enable(en),
    .O_armed(armed),
    .O_done(done),
    .O_trig_count(cnt),
    .O_state(st)
  );

  always #5 clk = ~clk;

  // reference model: phase names follow the documented state codes
  localparam int P_IDLE = 0, P_ARMED = 1, P_DELAY = 2;
  localparam int P_CAP = 3, P_HOLD = 4, P_DONE = 5;

  int m_phase, m_cnt, m_d, m_w, m_n;
  int cyc, fire_at, cap_from;
  bit m_arm_r, m_trig_r, m_seen;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic finish_window();
    int need;
    m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
    need = (m_n == 0) ? 1 : m_n;
    m_phase = (m_cnt >= need) ? P_DONE : P_HOLD;
  endtask

  task automatic model_step();
    bit arise, trise;
    cyc++;
    if (!rst_n) begin
      m_phase = P_IDLE; m_cnt = 0;
      m_d = 0; m_w = 0; m_n = 0;
      m_arm_r = 0; m_trig_r = 0; m_seen = 0;
      return;
    end
    arise = arm && !m_arm_r;
    trise = trig && !m_trig_r;
    if (abort || !arm) begin
      m_phase = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: if (arise) begin
          m_phase = P_ARMED; m_cnt = 0;
        end
        P_ARMED: if (trise) begin
          if (m_d == 0) begin
            m_phase = P_CAP; cap_from = cyc; m_seen = 0;
          end else begin
            m_phase = P_DELAY; fire_at = cyc + m_d;
          end
        end
        P_DELAY: if (cyc == fire_at) begin
          m_phase = P_CAP; cap_from = cyc; m_seen = 0;
        end
        P_CAP: begin
          if (m_w != 0) begin
            if (cyc == cap_from + m_w) finish_window();
          end else if (m_seen && !capturing) begin
            finish_window();
          end else if (capturing) begin
            m_seen = 1;
          end
        end
        P_HOLD: if (!trig) m_phase = P_ARMED;
        default: m_phase = P_IDLE;
      endcase
    end
    if (arise) begin
      m_d = int'(dly); m_w = int'(wid); m_n = int'(num);
    end
    m_arm_r = arm;
    m_trig_r = trig;
  endtask

  task automatic tick();
    bit x_armed;
    @(posedge clk);
    model_step();
    @(negedge clk);
    x_armed = (m_phase >= P_ARMED) && (m_phase <= P_HOLD);
    chk("state", 32'(st), 32'(m_phase));
    chk("enable", 32'(en), 32'(m_phase == P_CAP));
    chk("armed", 32'(armed), 32'(x_armed));
    chk("done", 32'(done), 32'(m_phase == P_DONE));
    chk("count", 32'(cnt), 32'(m_cnt));
  endtask

  task automatic setup(input int d, input int w, input int n);
    dly = DW'(d); wid = WW'(w); num = CW'(n);
  endtask

  task automatic idle_out();
    arm = 0; trig = 0; abort = 0; capturing = 0;
    tick();
  endtask

  initial begin
    cyc = 0;
    rst_n = 0; arm = 0; abort = 0; trig = 0; capturing = 0;
    setup(0, 0, 0);
    tick(); tick();
    chk("rst_state", 32'(st), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_armed", 32'(armed), 0);
    rst_n = 1;
    tick();

    // single window, no delay
    setup(0, 4, 1);
    arm = 1; tick(); tick();
    trig = 1; tick();
    for (int i = 0; i < 4; i++) begin
      chk("t1_en_hi", 32'(en), 1);
      tick();
    end
    chk("t1_en_lo", 32'(en), 0);
    chk("t1_state", 32'(st), 5);
    chk("t1_count", 32'(cnt), 1);
    chk("t1_done", 32'(done), 1);
    trig = 0; arm = 0; tick();
    chk("t1_idle", 32'(st), 0);
    chk("t1_held", 32'(cnt), 1);

    // three delayed windows
    setup(10, 3, 3);
    arm = 1; tick(); tick();
    for (int k = 0; k < 3; k++) begin
      trig = 1; tick();
      trig = 0;
      for (int j = 1; j < 30; j++) begin
        tick();
        chk("t2_win", 32'(en), 32'(j >= 10 && j <= 12));
      end
    end
    chk("t2_state", 32'(st), 5);
    chk("t2_count", 32'(cnt), 3);
    idle_out();

    // trigger held across a window
    setup(1, 2, 2);
    arm = 1; tick(); tick();
    trig = 1; tick();
    for (int i = 0; i < 8; i++) tick();
    chk("t3_hold", 32'(st), 4);
    trig = 0; tick();
    chk("t3_rearm", 32'(st), 1);
    tick();
    chk("t3_armed", 32'(st), 1);
    trig = 1; tick();
    for (int i = 0; i < 4; i++) tick();
    chk("t3_done", 32'(st), 5);
    chk("t3_count", 32'(cnt), 2);
    idle_out();

    // open-ended window following the datapath
    setup(0, 0, 1);
    arm = 1; tick(); tick();
    trig = 1; tick();
    trig = 0; capturing = 1;
    for (int i = 0; i < 50; i++) tick();
    chk("t4_en_on", 32'(en), 1);
    capturing = 0; tick();
    chk("t4_en_off", 32'(en), 0);
    chk("t4_count", 32'(cnt), 1);
    idle_out();

    // abort mid-capture keeps the count
    setup(0, 2, 3);
    arm = 1; tick(); tick();
    trig = 1; tick();
    trig = 0;
    for (int i = 0; i < 4; i++) tick();
    trig = 1; tick();
    abort = 1; tick();
    abort = 0;
    chk("t5_abort_st", 32'(st), 0);
    chk("t5_abort_en", 32'(en), 0);
    chk("t5_abort_cnt", 32'(cnt), 1);
    idle_out();

    // reset mid-delay
    setup(10, 3, 1);
    arm = 1; tick(); tick();
    trig = 1; tick();
    trig = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_delay", 32'(st), 2);
    rst_n = 0; arm = 0; tick();
    chk("t5_rst_st", 32'(st), 0);
    chk("t5_rst_armed", 32'(armed), 0);
    rst_n = 1; tick();

    // trigger coincident with arm is ignored; N=0 acts as 1
    setup(2, 2, 0);
    arm = 1; trig = 1; tick(); tick();
    chk("t6_armed", 32'(st), 1);
    trig = 0; tick();
    trig = 1; tick();
    trig = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_done", 32'(st), 5);
    chk("t6_count", 32'(cnt), 1);
    idle_out();

    // randomized traffic
    for (int e = 0; e < 20; e++) begin
      setup($urandom_range(0, 12), $urandom_range(0, 5),
            $urandom_range(0, 3));
      arm = 0; tick(); tick();
      arm = 1;
      for (int c = 0; c < 150; c++) begin
        tick();
        abort = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 5) == 0) trig = ~trig;
        if ($urandom_range(0, 7) == 0) capturing = ~capturing;
        if (arm) begin
          if ($urandom_range(0, 299) == 0) arm = 0;
        end else if ($urandom_range(0, 4) == 0) begin
          arm = 1;
        end
        if ($urandom_range(0, 49) == 0)
          setup($urandom_range(0, 12), $urandom_range(0, 5),
                $urandom_range(0, 3));
        rst_n = ($urandom_range(0, 499) != 0);
      end
      rst_n = 1; abort = 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
